// File: rtl/mdc_dispense_sequencer_if.sv
// Front-panel inputs and actuator/status outputs of the coffee dispense sequencer.
// The testbench drives through the master modport; the sequencer uses the slave modport.
interface mdc_dispense_sequencer_if #(
   parameter int CREDIT_W = 5
);
   logic                i_mc;
   logic                i_md;
   logic                i_bc;
   logic                i_bt;
   logic                i_bcan;
   logic                i_ha;
   logic                i_hc;
   logic                i_ht;
   logic                o_heat_on;
   logic                o_pump_on;
   logic                o_cafe_sel;
   logic                o_te_sel;
   logic                o_coin_reject;
   logic                o_change_valid;
   logic [CREDIT_W-1:0] o_change_amt;
   logic [CREDIT_W-1:0] o_credit;
   logic                o_busy;
   logic [1:0]          o_err;

   modport master (
      output i_mc, i_md, i_bc, i_bt, i_bcan, i_ha, i_hc, i_ht,
      input  o_heat_on, o_pump_on, o_cafe_sel, o_te_sel, o_coin_reject,
             o_change_valid, o_change_amt, o_credit, o_busy, o_err
   );

   modport slave (
      input  i_mc, i_md, i_bc, i_bt, i_bcan, i_ha, i_hc, i_ht,
      output o_heat_on, o_pump_on, o_cafe_sel, o_te_sel, o_coin_reject,
             o_change_valid, o_change_amt, o_credit, o_busy, o_err
   );
endinterface

// File: rtl/mdc_dispense_sequencer.sv
// Coin credit accumulator and heat/pour dispense FSM with change return.
// Optional idle-credit auto-cancel is enabled by defining MDC_SEQ_AUTOCANCEL_EN.
module mdc_dispense_sequencer #(
   parameter int CREDIT_W   = 5,
   parameter int PRICE_CAFE = 10,
   parameter int PRICE_TE   = 5,
   parameter int MAX_CREDIT = 20,
   parameter int CNT_W      = 6,
   parameter int T_HEAT     = 8,
   parameter int T_POUR     = 12,
   parameter int TIMEOUT    = 63
)(
   input  logic                      clk,
   input  logic                      rst,
   mdc_dispense_sequencer_if.slave   bus
);
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CREDIT = 3'd1,
      S_CHECK  = 3'd2,
      S_HEAT   = 3'd3,
      S_POUR   = 3'd4,
      S_CHANGE = 3'd5
   } state_t;

   localparam logic [CREDIT_W:0]  LP_ZERO       = {(CREDIT_W+1){1'b0}};
   localparam logic [CREDIT_W:0]  LP_PRICE_CAFE = (CREDIT_W+1)'(PRICE_CAFE);
   localparam logic [CREDIT_W:0]  LP_PRICE_TE   = (CREDIT_W+1)'(PRICE_TE);
   localparam logic [CREDIT_W:0]  LP_MAX        = (CREDIT_W+1)'(MAX_CREDIT);
   localparam logic [CREDIT_W:0]  LP_COIN5      = (CREDIT_W+1)'(5);
   localparam logic [CREDIT_W:0]  LP_COIN10     = (CREDIT_W+1)'(10);
   localparam logic [CNT_W-1:0]   LP_CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]   LP_HEAT_LAST  = CNT_W'(T_HEAT - 1);
   localparam logic [CNT_W-1:0]   LP_POUR_LAST  = CNT_W'(T_POUR - 1);
   localparam logic [CNT_W-1:0]   LP_TMO_LAST   = CNT_W'(TIMEOUT - 1);

   state_t              r_state, w_state_nx;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nx;
   logic [CREDIT_W-1:0] r_credit, w_credit_nx;
   logic                r_cafe_sel, w_cafe_nx;
   logic                r_te_sel, w_te_nx;
   logic [1:0]          r_err, w_err_nx;
   logic                r_coin_reject, w_rej_nx;
   logic                r_heat_on, r_pump_on, r_busy;
   logic                r_change_valid;
   logic [CREDIT_W-1:0] r_change_amt;
   logic [CNT_W-1:0]    r_tmo, w_tmo_nx;
   logic [CREDIT_W:0]   w_refund;
   logic                w_go_change;

   wire                 w_any_coin = bus.i_mc | bus.i_md;
   wire                 w_any_btn  = bus.i_bc | bus.i_bt;
   wire [CREDIT_W:0]    w_credit_x = {1'b0, r_credit};
   wire [CREDIT_W:0]    w_coin_amt = (bus.i_mc ? LP_COIN5 : LP_ZERO) + (bus.i_md ? LP_COIN10 : LP_ZERO);
   wire [CREDIT_W:0]    w_sum      = w_credit_x + w_coin_amt;
   wire [CREDIT_W:0]    w_price    = r_cafe_sel ? LP_PRICE_CAFE : LP_PRICE_TE;
   wire [CREDIT_W:0]    w_btn_price = bus.i_bc ? LP_PRICE_CAFE : LP_PRICE_TE;

   // Next-state, credit, selection, error and refund decisions.
   always_comb begin
      w_state_nx  = r_state;
      w_cnt_nx    = r_cnt;
      w_credit_nx = r_credit;
      w_cafe_nx   = r_cafe_sel;
      w_te_nx     = r_te_sel;
      w_err_nx    = r_err;
      w_rej_nx    = 1'b0;
      w_refund    = LP_ZERO;
      w_go_change = 1'b0;
      w_tmo_nx    = LP_CNT_ZERO;
      case (r_state)
         S_IDLE, S_CREDIT: begin
            if ((r_state == S_CREDIT) && bus.i_bcan) begin
               w_err_nx    = 2'b00;
               w_refund    = w_credit_x;
               w_go_change = 1'b1;
               w_rej_nx    = w_any_coin;
            end else if ((r_state == S_CREDIT) && w_any_btn) begin
               // Coffee wins over tea; a coin in the same cycle cannot be added.
               w_rej_nx = w_any_coin;
               if (w_credit_x < w_btn_price) begin
                  w_err_nx = 2'b01;
               end else begin
                  w_err_nx   = 2'b00;
                  w_cafe_nx  = bus.i_bc;
                  w_te_nx    = ~bus.i_bc;
                  w_state_nx = S_CHECK;
               end
            end else if (w_any_coin) begin
               if (w_sum <= LP_MAX) begin
                  w_credit_nx = w_sum[CREDIT_W-1:0];
                  w_err_nx    = 2'b00;
                  w_state_nx  = S_CREDIT;
               end else begin
                  w_rej_nx = 1'b1;
               end
`ifdef MDC_SEQ_AUTOCANCEL_EN
            end else if (r_state == S_CREDIT) begin
               if (r_tmo == LP_TMO_LAST) begin
                  w_err_nx    = 2'b00;
                  w_refund    = w_credit_x;
                  w_go_change = 1'b1;
               end else begin
                  w_tmo_nx = r_tmo + {{(CNT_W-1){1'b0}}, 1'b1};
               end
`endif
            end else begin
               w_state_nx = r_state;
            end
         end
         S_CHECK: begin
            w_rej_nx = w_any_coin;
            if (bus.i_ha && (r_cafe_sel ? bus.i_hc : bus.i_ht)) begin
               w_state_nx = S_HEAT;
               w_cnt_nx   = LP_CNT_ZERO;
            end else begin
               w_err_nx    = 2'b10;
               w_refund    = w_credit_x;
               w_go_change = 1'b1;
            end
         end
         S_HEAT: begin
            w_rej_nx = w_any_coin;
            if (!bus.i_ha) begin
               w_err_nx    = 2'b11;
               w_refund    = w_credit_x;
               w_go_change = 1'b1;
            end else if (r_cnt == LP_HEAT_LAST) begin
               w_state_nx = S_POUR;
               w_cnt_nx   = LP_CNT_ZERO;
            end else begin
               w_cnt_nx = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         S_POUR: begin
            w_rej_nx = w_any_coin;
            if (!bus.i_ha) begin
               w_err_nx    = 2'b11;
               w_refund    = w_credit_x - w_price;
               w_go_change = 1'b1;
            end else if (r_cnt == LP_POUR_LAST) begin
               w_refund    = w_credit_x - w_price;
               w_go_change = 1'b1;
            end else begin
               w_cnt_nx = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         S_CHANGE: begin
            w_rej_nx   = w_any_coin;
            w_state_nx = S_IDLE;
         end
         default: begin
            w_state_nx = S_IDLE;
         end
      endcase
      if (w_go_change) begin
         w_state_nx  = S_CHANGE;
         w_credit_nx = {CREDIT_W{1'b0}};
         w_cafe_nx   = 1'b0;
         w_te_nx     = 1'b0;
      end else begin
         w_state_nx = w_state_nx;
      end
   end

   // State and registered outputs; outputs are decoded from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_cnt          <= LP_CNT_ZERO;
         r_credit       <= {CREDIT_W{1'b0}};
         r_cafe_sel     <= 1'b0;
         r_te_sel       <= 1'b0;
         r_err          <= 2'b00;
         r_coin_reject  <= 1'b0;
         r_heat_on      <= 1'b0;
         r_pump_on      <= 1'b0;
         r_busy         <= 1'b0;
         r_change_valid <= 1'b0;
         r_change_amt   <= {CREDIT_W{1'b0}};
         r_tmo          <= LP_CNT_ZERO;
      end else begin
         r_state        <= w_state_nx;
         r_cnt          <= w_cnt_nx;
         r_credit       <= w_credit_nx;
         r_cafe_sel     <= w_cafe_nx;
         r_te_sel       <= w_te_nx;
         r_err          <= w_err_nx;
         r_coin_reject  <= w_rej_nx;
         r_heat_on      <= (w_state_nx == S_HEAT);
         r_pump_on      <= (w_state_nx == S_POUR);
         r_busy         <= (w_state_nx == S_CHECK) || (w_state_nx == S_HEAT) ||
                           (w_state_nx == S_POUR)  || (w_state_nx == S_CHANGE);
         r_change_valid <= w_go_change && (w_refund != LP_ZERO);
         r_change_amt   <= w_go_change ? w_refund[CREDIT_W-1:0] : {CREDIT_W{1'b0}};
         r_tmo          <= w_tmo_nx;
      end
   end

   assign bus.o_heat_on      = r_heat_on;
   assign bus.o_pump_on      = r_pump_on;
   assign bus.o_cafe_sel     = r_cafe_sel;
   assign bus.o_te_sel       = r_te_sel;
   assign bus.o_coin_reject  = r_coin_reject;
   assign bus.o_change_valid = r_change_valid;
   assign bus.o_change_amt   = r_change_amt;
   assign bus.o_credit       = r_credit;
   assign bus.o_busy         = r_busy;
   assign bus.o_err          = r_err;
endmodule
